// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder controller feeding an external 1-bit full adder, LSB first.
// Defining SERIAL_ADD_OVF_EN adds the registered signed-overflow output ovf.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in0,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_s,
  input  logic             fa_cout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] a_sh, b_sh, sum_sh;
  logic carry_q;
  logic [CW-1:0] cnt;
  logic last;
  assign last = cnt == CW'(WIDTH - 1);
  assign fa_a = a_sh[0];
  assign fa_b = b_sh[0];
  assign fa_cin = carry_q;
  assign busy = state == SHIFT;
  assign done = state == DONE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      a_sh <= '0;
      b_sh <= '0;
      sum_sh <= '0;
      carry_q <= 1'b0;
      cnt <= '0;
      sum <= '0;
      c_out <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf <= 1'b0;
`endif
    end else
      case (state)
        IDLE:
          if (start) begin
            a_sh <= a_in;
            b_sh <= b_in;
            carry_q <= c_in0;
            cnt <= '0;
            state <= SHIFT;
          end
        SHIFT: begin
          sum_sh <= {fa_s, sum_sh[WIDTH-1:1]};
          carry_q <= fa_cout;
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          cnt <= cnt + CW'(1);
          if (last) begin
            sum <= {fa_s, sum_sh[WIDTH-1:1]};
            c_out <= fa_cout;
`ifdef SERIAL_ADD_OVF_EN
            // carry into the MSB differs from carry out of it
            ovf <= carry_q ^ fa_cout;
`endif
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: table, random and hand-written sequences for serial_adder_ctrl (WIDTH=8).
module tb_serial_adder_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, c_in0 = 1'b0;
  logic [7:0] a_in = '0, b_in = '0, sum;
  logic fa_a, fa_b, fa_cin, fa_s, fa_cout, busy, done, c_out;
`ifdef SERIAL_ADD_OVF_EN
  logic ovf;
`endif
  int tests = 0, fails = 0, cyc = 0;

  serial_adder_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a_in(a_in), .b_in(b_in), .c_in0(c_in0),
    .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin), .fa_s(fa_s), .fa_cout(fa_cout),
    .busy(busy), .done(done), .sum(sum), .c_out(c_out)
`ifdef SERIAL_ADD_OVF_EN
    , .ovf(ovf)
`endif
  );

  assign {fa_cout, fa_s} = {1'b0, fa_a} + {1'b0, fa_b} + {1'b0, fa_cin};
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  typedef struct {
    logic [7:0] a, b;
    logic c;
    logic [7:0] s;
    logic co, ov;
  } vec_t;
  vec_t tv[7];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
    end
  endtask

  task automatic wait_done(input string nm);
    int k = 0;
    while (!done && k < 30) begin
      @(negedge clk);
      k++;
    end
    chk({nm, "_done"}, 32'(done), 32'd1);
    chk({nm, "_not_busy_with_done"}, 32'(busy), 32'd0);
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic c,
                        input logic [7:0] es, input logic ec, input logic eo, input string nm);
    int bc = 0, k = 0;
    @(negedge clk);
    a_in = a; b_in = b; c_in0 = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a_in = ~a; b_in = ~b; c_in0 = ~c;
    while (!done && k < 30) begin
      if (busy) bc++;
      k++;
      @(negedge clk);
    end
    chk({nm, "_done"}, 32'(done), 32'd1);
    chk({nm, "_busy_cycles"}, 32'(bc), 32'd8);
    chk({nm, "_sum"}, 32'(sum), 32'(es));
    chk({nm, "_c_out"}, 32'(c_out), 32'(ec));
`ifdef SERIAL_ADD_OVF_EN
    chk({nm, "_ovf"}, 32'(ovf), 32'(eo));
`else
    if (eo === 1'bx) $display("note: unknown overflow expectation");
`endif
    @(negedge clk);
    chk({nm, "_done_one_cycle"}, 32'(done), 32'd0);
    chk({nm, "_sum_held"}, 32'(sum), 32'(es));
  endtask

  initial begin
    logic [8:0] r;
    logic [7:0] ra, rb, pa, pb;
    logic rc, rov;
    int t1, dn;
    tv[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1};
    tv[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    tv[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    tv[3] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
    tv[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    tv[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    tv[6] = '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0};
    #2;
    chk("reset_outputs", 32'({busy, done, sum, c_out, fa_a, fa_b, fa_cin}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++)
      run_op(tv[i].a, tv[i].b, tv[i].c, tv[i].s, tv[i].co, tv[i].ov, $sformatf("vec%0d", i));
    for (int i = 0; i < 20; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom_range(0, 1));
      r = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
      rov = (ra[7] == rb[7]) && (r[7] != ra[7]);
      run_op(ra, rb, rc, r[7:0], r[8], rov, $sformatf("rnd%0d", i));
    end
    // carry-in is presented only on the first bit
    @(negedge clk);
    a_in = 8'h00; b_in = 8'h00; c_in0 = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("cin_first_cycle", 32'(fa_cin), 32'd1);
    @(negedge clk);
    chk("cin_second_cycle", 32'(fa_cin), 32'd0);
    wait_done("cin");
    chk("cin_sum", 32'({c_out, sum}), 32'h001);
    // start held high; operands change after each acceptance
    @(negedge clk);
    a_in = 8'h11; b_in = 8'h22; c_in0 = 1'b0; start = 1'b1;
    @(negedge clk);
    a_in = 8'h33; b_in = 8'h44;
    wait_done("hold1");
    chk("hold1_sum", 32'(sum), 32'h33);
    t1 = cyc;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    a_in = 8'hF0; b_in = 8'hF0;
    wait_done("hold2");
    start = 1'b0;
    chk("hold_period", 32'(cyc - t1), 32'd10);
    chk("hold2_sum", 32'(sum), 32'h77);
    @(negedge clk);
    @(negedge clk);
    chk("hold_stop", 32'({busy, done}), 32'd0);
    // asynchronous reset mid-operation
    a_in = 8'hFF; b_in = 8'hFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_outputs", 32'({busy, done, sum, c_out, fa_a, fa_b, fa_cin}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk("abort_no_done", 32'(dn), 32'd0);
    run_op(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, "after_abort");
    // start raised during DONE is ignored until IDLE
    @(negedge clk);
    a_in = 8'h01; b_in = 8'h02; c_in0 = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("b2b1");
    chk("b2b1_sum", 32'(sum), 32'h03);
    pa = 8'h40; pb = 8'h05;
    a_in = pa; b_in = pb; start = 1'b1;
    @(negedge clk);
    chk("b2b_idle_gap", 32'({busy, done}), 32'd0);
    @(negedge clk);
    start = 1'b0;
    chk("b2b_accepted", 32'(busy), 32'd1);
    wait_done("b2b2");
    chk("b2b2_sum", 32'(sum), 32'(pa + pb));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
